// File: rtl/demux_pkg.sv
// Shared types and constants for the buffered 1-to-4 demultiplexer.
// Channel FIFO state encoding and the select-to-one-hot helper live here.
package demux_pkg;

  localparam int NUM_CHAN = 4;
  localparam int SEL_W    = 2;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } chan_state_t;

  function automatic logic [NUM_CHAN-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_CHAN-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// One output channel: small FIFO with occupancy counter and EMPTY/PARTIAL/FULL state.
// Pushes while FULL and pops while EMPTY are ignored, so callers may gate loosely.
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  chan_state_t      state_q;
  logic             do_push, do_pop;

  assign do_push = push & (state_q != FULL);
  assign do_pop  = pop  & (state_q != EMPTY);

  // NOTE: every variable gets a default at the top of always_comb, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: storage is not reset; state_q gates every read, so stale contents can never reach dout.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= EMPTY;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      case (state_q)
        EMPTY:   if (do_push) state_q <= PARTIAL;
        PARTIAL: begin
          if (occ_d == OCC_W'(DEPTH))  state_q <= FULL;
          else if (occ_d == '0)        state_q <= EMPTY;
        end
        FULL:    if (do_pop) state_q <= PARTIAL;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign valid = (state_q != EMPTY);
  assign full  = (state_q == FULL);
  assign dout  = valid ? mem_q[rd_ptr_q] : '0;

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n) occ_q <= OCC_W'(DEPTH));
  a_state_occ: assert property (@(posedge clk) disable iff (!rst_n)
                                (state_q == EMPTY) == (occ_q == '0));

endmodule

// File: rtl/demux_1to4_32bit_buf.sv
// Buffered 1-to-4 demultiplexer: steers each accepted word to FIFO[Select].
// InReady depends only on Select and FIFO state, never on InValid or OutReady.
module demux_1to4_32bit_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [WIDTH-1:0]    In,
  input  logic [SEL_W-1:0]    Select,
  input  logic                InValid,
  output logic                InReady,
  output logic [WIDTH-1:0]    Out0,
  output logic [WIDTH-1:0]    Out1,
  output logic [WIDTH-1:0]    Out2,
  output logic [WIDTH-1:0]    Out3,
  output logic [NUM_CHAN-1:0] OutValid,
  input  logic [NUM_CHAN-1:0] OutReady,
  output logic                Busy
);

  logic [NUM_CHAN-1:0]            full;
  logic [NUM_CHAN-1:0]            push;
  logic [NUM_CHAN-1:0]            pop;
  logic [NUM_CHAN-1:0][WIDTH-1:0] dout;
  logic                           accept;

  assign InReady = ~full[Select];
  assign accept  = InValid & InReady;
  assign push    = accept ? sel_decode(Select) : '0;
  assign pop     = OutValid & OutReady;

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
    demux_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (Clock),
      .rst_n (Reset_n),
      .push  (push[g]),
      .din   (In),
      .pop   (pop[g]),
      .dout  (dout[g]),
      .valid (OutValid[g]),
      .full  (full[g])
    );
  end

  assign Out0 = dout[0];
  assign Out1 = dout[1];
  assign Out2 = dout[2];
  assign Out3 = dout[3];
  assign Busy = |OutValid;

  a_push_onehot: assert property (@(posedge Clock) disable iff (!Reset_n) $onehot0(push));

endmodule

// File: tb/tb_demux_1to4_32bit_buf.sv
// Scoreboard bench: two DUT instances (DEPTH=2 and DEPTH=4) share stimulus;
// per-channel expected-word queues model the FIFOs, a negedge monitor compares and pops.
module tb_demux_1to4_32bit_buf;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [31:0] In;
  logic [1:0]  Select;
  logic        InValid;
  logic [3:0]  OutReady;

  logic [3:0][31:0] out_a, out_b;
  logic [3:0]       ov_a, ov_b;
  logic             ir_a, ir_b, busy_a, busy_b;

  demux_1to4_32bit_buf #(.WIDTH(32), .DEPTH(2)) u_dut_d2 (
    .Clock(Clock), .Reset_n(Reset_n), .In(In), .Select(Select), .InValid(InValid),
    .InReady(ir_a), .Out0(out_a[0]), .Out1(out_a[1]), .Out2(out_a[2]), .Out3(out_a[3]),
    .OutValid(ov_a), .OutReady(OutReady), .Busy(busy_a)
  );

  demux_1to4_32bit_buf #(.WIDTH(32), .DEPTH(4)) u_dut_d4 (
    .Clock(Clock), .Reset_n(Reset_n), .In(In), .Select(Select), .InValid(InValid),
    .InReady(ir_b), .Out0(out_b[0]), .Out1(out_b[1]), .Out2(out_b[2]), .Out3(out_b[3]),
    .OutValid(ov_b), .OutReady(OutReady), .Busy(busy_b)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  // exp_q[d][ch]: words accepted but not yet consumed; d=0 is DEPTH 2, d=1 is DEPTH 4
  logic [31:0] exp_q [2][4][$];

  function automatic int dep(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d,
                      input logic [3:0] r);
    bit pend [2];
    InValid  = v;
    Select   = s;
    In       = d;
    OutReady = r;
    for (int k = 0; k < 2; k++)
      pend[k] = v && Reset_n && (exp_q[k][s].size() < dep(k));
    @(posedge Clock);
    for (int k = 0; k < 2; k++)
      if (pend[k]) exp_q[k][s].push_back(d);
    #1;
  endtask

  task automatic drain();
    repeat (6) step(1'b0, 2'd0, 32'h0, 4'hF);
    check("drained d2 OutValid", {28'h0, ov_a}, 32'h0);
    check("drained d4 OutValid", {28'h0, ov_b}, 32'h0);
  endtask

  // Monitor: compare outputs against the model, then retire words consumed at the next edge.
  initial begin : monitor
    forever begin
      @(negedge Clock);
      for (int d = 0; d < 2; d++) begin
        logic [3:0][31:0] o;
        logic [3:0]       ov;
        logic             ir, bz, any;
        o   = (d == 0) ? out_a  : out_b;
        ov  = (d == 0) ? ov_a   : ov_b;
        ir  = (d == 0) ? ir_a   : ir_b;
        bz  = (d == 0) ? busy_a : busy_b;
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
          bit          has;
          logic [31:0] want;
          has  = exp_q[d][i].size() != 0;
          want = has ? exp_q[d][i][0] : 32'h0;
          any  = any | has;
          check($sformatf("depth%0d ch%0d OutValid", dep(d), i), {31'h0, ov[i]}, {31'h0, has});
          check($sformatf("depth%0d ch%0d Out", dep(d), i), o[i], want);
        end
        check($sformatf("depth%0d InReady sel%0d", dep(d), Select), {31'h0, ir},
              {31'h0, exp_q[d][Select].size() < dep(d)});
        check($sformatf("depth%0d Busy", dep(d)), {31'h0, bz}, {31'h0, any});
        if (Reset_n)
          for (int i = 0; i < 4; i++)
            if (OutReady[i] && exp_q[d][i].size() != 0) void'(exp_q[d][i].pop_front());
      end
    end
  end

  initial begin : stimulus
    int acc;
    // 1. reset held with a word offered: nothing captured, InReady reads 1
    Reset_n  = 1'b0;
    InValid  = 1'b1;
    Select   = 2'd2;
    In       = 32'hDEAD_BEEF;
    OutReady = 4'h0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset InReady", {31'h0, ir_a}, 32'h1);
    check("reset OutValid", {28'h0, ov_a}, 32'h0);
    check("reset Out2", out_a[2], 32'h0);
    Reset_n = 1'b1;
    step(1'b1, 2'd2, 32'hDEAD_BEEF, 4'h0);
    check("first push OutValid", {28'h0, ov_a}, 32'h4);
    check("first push Out2", out_a[2], 32'hDEAD_BEEF);
    drain();

    // 2. fill channel 1, back-pressure, then release in order
    step(1'b1, 2'd1, 32'h1, 4'h0);
    step(1'b1, 2'd1, 32'h2, 4'h0);
    step(1'b0, 2'd1, 32'h0, 4'h0);
    step(1'b0, 2'd0, 32'h0, 4'h0);
    step(1'b1, 2'd1, 32'h3, 4'h0);
    step(1'b1, 2'd1, 32'h3, 4'h0);
    step(1'b1, 2'd1, 32'h3, 4'h2);
    step(1'b1, 2'd1, 32'h3, 4'h2);
    drain();

    // 3. channel 3 at occ=1, simultaneous push and pop every cycle
    step(1'b1, 2'd3, 32'hA5A5_A5A5, 4'h0);
    for (int k = 0; k < 8; k++) step(1'b1, 2'd3, 32'hA5A5_A5A5 ^ k, 4'h8);
    check("ch3 still valid after streaming", {31'h0, ov_a[3]}, 32'h1);
    drain();

    // 4. round-robin select with all consumers ready
    for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 32'h10 + k, 4'hF);
    drain();

    // 5. fill channel 0, then asynchronous reset mid-cycle
    step(1'b1, 2'd0, 32'hC0DE_0001, 4'h0);
    step(1'b1, 2'd0, 32'hC0DE_0002, 4'h0);
    #2;
    Reset_n = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) exp_q[d][i].delete();
    #1;
    check("async reset OutValid d2", {28'h0, ov_a}, 32'h0);
    check("async reset OutValid d4", {28'h0, ov_b}, 32'h0);
    check("async reset Out0", out_a[0], 32'h0);
    check("async reset Busy", {31'h0, busy_a}, 32'h0);
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    Reset_n = 1'b1;
    drain();

    // 6. interleaved push/pop on channel 0 with random consumer readiness
    acc = 0;
    for (int c = 0; c < 120 && acc < 11; c++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      if (v && exp_q[1][0].size() < 4) acc++;
      step(v, 2'd0, $urandom, {3'b000, 1'($urandom_range(0, 1))});
    end
    drain();

    // random soak across all channels
    for (int c = 0; c < 300; c++)
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
           4'($urandom_range(0, 15)));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
